// File: rtl/lcd_pkg.sv
// Shared constants for the LCD window-fill sequencer: panel defaults, ST7789-style
// opcodes, FSM state codes and the address-parameter byte selector.
package lcd_pkg;

    localparam int unsigned H_RES_DEF = 320;
    localparam int unsigned V_RES_DEF = 240;
    localparam int unsigned COORD_W   = 9;

    localparam logic [7:0] OP_CASET = 8'h2A;
    localparam logic [7:0] OP_PASET = 8'h2B;
    localparam logic [7:0] OP_RAMWR = 8'h2C;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CASET_CMD = 3'd1;
    localparam logic [2:0] ST_CASET_PAR = 3'd2;
    localparam logic [2:0] ST_PASET_CMD = 3'd3;
    localparam logic [2:0] ST_PASET_PAR = 3'd4;
    localparam logic [2:0] ST_RAMWR_CMD = 3'd5;
    localparam logic [2:0] ST_PIXEL     = 3'd6;

    // Address parameters go out as start-hi, start-lo, end-hi, end-lo of 16-bit values.
    function automatic logic [7:0] par_byte(input logic [8:0] start_c,
                                            input logic [8:0] end_c,
                                            input logic [1:0] idx);
        logic [15:0] w;
        w = idx[1] ? {7'd0, end_c} : {7'd0, start_c};
        return idx[0] ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/lcd_fill_sequencer_if.sv
// Byte-level handshake between the fill sequencer and the SPI byte engine.
interface lcd_fill_sequencer_if;
    logic       spi_start;
    logic [7:0] spi_data;
    logic       spi_dc;
    logic       spi_done;

    modport master (output spi_start, output spi_data, output spi_dc, input spi_done);
    modport slave  (input spi_start, input spi_data, input spi_dc, output spi_done);
endinterface

// File: rtl/lcd_window_counter.sv
// Walks a window pixel by pixel: hi/lo byte phase, column, then row.
module lcd_window_counter
    import lcd_pkg::*;
#(
    parameter int unsigned W = COORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         step_i,
    input  logic [W-1:0] col_max_i,
    input  logic [W-1:0] row_max_i,
    output logic         phase_o,
    output logic         last_o
);

    logic [W-1:0] col_q, col_d;
    logic [W-1:0] row_q, row_d;
    logic         phase_q, phase_d;

    assign phase_o = phase_q;
    assign last_o  = (col_q == col_max_i) && (row_q == row_max_i);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        phase_d = phase_q;
        if (clr_i) begin
            col_d   = '0;
            row_d   = '0;
            phase_d = 1'b0;
        end else if (step_i) begin
            phase_d = ~phase_q;
            // Position only moves once both colour bytes of a pixel are gone.
            if (phase_q) begin
                if (last_o) begin
                    col_d = '0;
                    row_d = '0;
                end else if (col_q == col_max_i) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/lcd_fill_sequencer.sv
// Issues CASET/PASET/RAMWR and streams a solid RGB565 colour into a panel window,
// one byte per SPI-engine handshake, paced by the byte-clock enable.
module lcd_fill_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  req,
    input  logic [8:0]            x0,
    input  logic [8:0]            x1,
    input  logic [8:0]            y0,
    input  logic [8:0]            y1,
    input  logic [15:0]           color,
    lcd_fill_sequencer_if.master  spi,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);

    logic [2:0]  state_q, state_d;
    logic [1:0]  pidx_q, pidx_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [8:0]  x0_q, x1_q, y0_q, y1_q;
    logic [15:0] color_q;

    logic        accept, bad_win, load, consume, pix_step;
    logic        phase, last_pix;
    logic [7:0]  data_c;
    logic        dc_c;

    assign busy    = (state_q != ST_IDLE);
    assign accept  = en && req && (state_q == ST_IDLE);
    assign bad_win = (x0 > x1) || (y0 > y1) || ({1'b0, x1} >= H_LIM) || ({1'b0, y1} >= V_LIM);
    assign load    = accept && !bad_win;
    // A byte is taken only while one is actually on offer and the byte clock ticks.
    assign consume  = en && spi.spi_done && busy;
    assign pix_step = consume && (state_q == ST_PIXEL);

    lcd_window_counter #(.W(COORD_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (load),
        .step_i    (pix_step),
        .col_max_i (x1_q - x0_q),
        .row_max_i (y1_q - y0_q),
        .phase_o   (phase),
        .last_o    (last_pix)
    );

    always_comb begin
        state_d = state_q;
        pidx_d  = pidx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_win) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_CASET_CMD;
                        pidx_d  = 2'd0;
                    end
                end
            end
            ST_CASET_CMD: if (consume) state_d = ST_CASET_PAR;
            ST_CASET_PAR: begin
                if (consume) begin
                    pidx_d = pidx_q + 2'd1;
                    if (pidx_q == 2'd3) state_d = ST_PASET_CMD;
                end
            end
            ST_PASET_CMD: if (consume) state_d = ST_PASET_PAR;
            ST_PASET_PAR: begin
                if (consume) begin
                    pidx_d = pidx_q + 2'd1;
                    if (pidx_q == 2'd3) state_d = ST_RAMWR_CMD;
                end
            end
            ST_RAMWR_CMD: if (consume) state_d = ST_PIXEL;
            ST_PIXEL: begin
                if (consume && phase && last_pix) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_c = 8'h00;
        dc_c   = 1'b0;
        case (state_q)
            ST_CASET_CMD: data_c = OP_CASET;
            ST_CASET_PAR: begin
                data_c = par_byte(x0_q, x1_q, pidx_q);
                dc_c   = 1'b1;
            end
            ST_PASET_CMD: data_c = OP_PASET;
            ST_PASET_PAR: begin
                data_c = par_byte(y0_q, y1_q, pidx_q);
                dc_c   = 1'b1;
            end
            ST_RAMWR_CMD: data_c = OP_RAMWR;
            ST_PIXEL: begin
                data_c = phase ? color_q[7:0] : color_q[15:8];
                dc_c   = 1'b1;
            end
            default: ;
        endcase
    end

    assign spi.spi_start = busy;
    assign spi.spi_data  = data_c;
    assign spi.spi_dc    = dc_c;
    assign done          = done_q;
    assign err           = err_q;

    // done/err are deliberately not gated by en so they stay single-clock pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pidx_q  <= 2'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pidx_q  <= pidx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else if (load) begin
            x0_q    <= x0;
            x1_q    <= x1;
            y0_q    <= y0;
            y1_q    <= y1;
            color_q <= color;
        end
    end

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Directed bench for lcd_fill_sequencer: default 320x240 instance plus a 40x30
// instance that makes a complete full-panel fill short enough to stream end to end.
module tb_lcd_fill_sequencer;

    logic        clk;
    logic        rst;
    logic        en, req;
    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] color;
    logic        busy, done, err;

    logic        en_s, req_s;
    logic [8:0]  x0_s, x1_s, y0_s, y1_s;
    logic [15:0] color_s;
    logic        busy_s, done_s, err_s;

    lcd_fill_sequencer_if sif ();
    lcd_fill_sequencer_if sif_s ();

    lcd_fill_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .spi(sif), .busy(busy), .done(done), .err(err)
    );

    lcd_fill_sequencer #(.H_RES(40), .V_RES(30)) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .req(req_s),
        .x0(x0_s), .x1(x1_s), .y0(y0_s), .y1(y1_s), .color(color_s),
        .spi(sif_s), .busy(busy_s), .done(done_s), .err(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [8:0] bytes_q[$];
    int         done_cnt, err_cnt, done_k;
    bit         busy_seen, start_seen, timed_out;

    logic [8:0] exp_small [15] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
                                   9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
                                   9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100};

    // Drives one request and records every byte at the edge that consumes it.
    task automatic run_fill(input int en_mode, input int sd_mode, input int max_cyc,
                            input int stop_bytes, input int pulse_at);
        bit pulsed;
        pulsed = 1'b0;
        bytes_q.delete();
        done_cnt = 0; err_cnt = 0; done_k = -1;
        busy_seen = 1'b0; start_seen = 1'b0; timed_out = 1'b1;
        req = 1'b1;
        for (int k = 0; k < max_cyc; k++) begin
            if (en_mode == 1) en = ((k % 2) == 0);
            else              en = 1'b1;
            if (sd_mode == 4) sif.spi_done = ((k % 4) == 3);
            else              sif.spi_done = 1'b1;
            if (pulse_at > 0 && !pulsed && bytes_q.size() == pulse_at) begin
                req    = 1'b1;
                x1     = 9'd3;
                pulsed = 1'b1;
            end
            if (sif.spi_start) start_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (en && sif.spi_done && sif.spi_start) bytes_q.push_back({sif.spi_dc, sif.spi_data});
            @(posedge clk); #1;
            req = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (err) err_cnt++;
            if (sif.spi_start) start_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (stop_bytes > 0 && bytes_q.size() >= stop_bytes) begin
                timed_out = 1'b0;
                break;
            end
            if (done_k >= 0 && k >= done_k + 4) begin
                timed_out = 1'b0;
                break;
            end
        end
        en = 1'b1;
        sif.spi_done = 1'b0;
    endtask

    task automatic set_small_window();
        x0 = 9'd0; x1 = 9'd1; y0 = 9'd0; y1 = 9'd0; color = 16'hF800;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sif.spi_start !== 1'b0 || sif.spi_data !== 8'h00 || sif.spi_dc !== 1'b0) begin
            bad++;
            $display("FAIL reset_spi: start=%b data=%h dc=%b required 0/00/0", sif.spi_start, sif.spi_data, sif.spi_dc);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%b done=%b err=%b required 0/0/0", busy, done, err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || sif.spi_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b start=%b required 0/0", busy, sif.spi_start);
        end
    endtask

    task automatic test_small_window();
        set_small_window();
        run_fill(0, 4, 200, 0, 0);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL small_timeout: done never seen, required one done");
        end
        total++;
        if (bytes_q.size() != 15) begin
            bad++;
            $display("FAIL small_len: got %0d bytes required 15", bytes_q.size());
        end
        for (int i = 0; i < 15 && i < bytes_q.size(); i++) begin
            total++;
            if (bytes_q[i] !== exp_small[i]) begin
                bad++;
                $display("FAIL small_byte%0d: got dc/data %h required %h", i, bytes_q[i], exp_small[i]);
            end
        end
        total++;
        if (done_cnt != 1 || done_k != 59) begin
            bad++;
            $display("FAIL small_done: count=%0d at_cycle=%0d required 1 at 59", done_cnt, done_k);
        end
        total++;
        if (busy !== 1'b0 || sif.spi_start !== 1'b0) begin
            bad++;
            $display("FAIL small_idle_after: busy=%b start=%b required 0/0", busy, sif.spi_start);
        end
    endtask

    task automatic test_en_toggle();
        set_small_window();
        run_fill(1, 1, 200, 0, 0);
        total++;
        if (bytes_q.size() != 15) begin
            bad++;
            $display("FAIL toggle_len: got %0d bytes required 15", bytes_q.size());
        end
        for (int i = 0; i < 15 && i < bytes_q.size(); i++) begin
            total++;
            if (bytes_q[i] !== exp_small[i]) begin
                bad++;
                $display("FAIL toggle_byte%0d: got dc/data %h required %h", i, bytes_q[i], exp_small[i]);
            end
        end
        total++;
        if (done_cnt != 1 || done_k != 30) begin
            bad++;
            $display("FAIL toggle_done: count=%0d at_cycle=%0d required 1 at 30", done_cnt, done_k);
        end
    endtask

    task automatic test_reject();
        x0 = 9'd5; x1 = 9'd4; y0 = 9'd0; y1 = 9'd0; color = 16'h1234;
        run_fill(0, 1, 10, 0, 0);
        total++;
        if (err_cnt != 1) begin
            bad++;
            $display("FAIL reject_x_err: err pulses=%0d required 1", err_cnt);
        end
        total++;
        if (start_seen || busy_seen || bytes_q.size() != 0) begin
            bad++;
            $display("FAIL reject_x_quiet: start=%b busy=%b bytes=%0d required 0/0/0", start_seen, busy_seen, bytes_q.size());
        end
        x0 = 9'd0; x1 = 9'd319; y0 = 9'd0; y1 = 9'd240;
        run_fill(0, 1, 10, 0, 0);
        total++;
        if (err_cnt != 1 || busy_seen) begin
            bad++;
            $display("FAIL reject_y_limit: err pulses=%0d busy=%b required 1/0", err_cnt, busy_seen);
        end
    endtask

    task automatic test_full_screen_header();
        x0 = 9'd0; x1 = 9'd319; y0 = 9'd0; y1 = 9'd239; color = 16'h07E0;
        run_fill(0, 1, 50, 11, 0);
        total++;
        if (timed_out || err_cnt != 0) begin
            bad++;
            $display("FAIL full_accept: timeout=%b err=%0d required 0/0", timed_out, err_cnt);
        end
        if (bytes_q.size() >= 11) begin
            total++;
            if (bytes_q[3] !== 9'h101 || bytes_q[4] !== 9'h13F) begin
                bad++;
                $display("FAIL full_x1: got %h %h required 101 13f", bytes_q[3], bytes_q[4]);
            end
            total++;
            if (bytes_q[8] !== 9'h100 || bytes_q[9] !== 9'h1EF || bytes_q[10] !== 9'h02C) begin
                bad++;
                $display("FAIL full_y1: got %h %h %h required 100 1ef 02c", bytes_q[8], bytes_q[9], bytes_q[10]);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_screen_small_panel();
        int nbytes, ndone, kdone;
        logic [8:0] b4, b9;
        nbytes = 0; ndone = 0; kdone = -1; b4 = '0; b9 = '0;
        en_s = 1'b1; sif_s.spi_done = 1'b1;
        x0_s = 9'd0; x1_s = 9'd40; y0_s = 9'd0; y1_s = 9'd29; color_s = 16'h001F;
        req_s = 1'b1;
        @(posedge clk); #1;
        req_s = 1'b0;
        total++;
        if (err_s !== 1'b1 || busy_s !== 1'b0) begin
            bad++;
            $display("FAIL panel_x_limit: err=%b busy=%b required 1/0", err_s, busy_s);
        end
        x1_s = 9'd39;
        req_s = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (sif_s.spi_start) begin
                if (nbytes == 4) b4 = {sif_s.spi_dc, sif_s.spi_data};
                if (nbytes == 9) b9 = {sif_s.spi_dc, sif_s.spi_data};
                nbytes++;
            end
            @(posedge clk); #1;
            req_s = 1'b0;
            if (done_s) begin
                ndone++;
                if (kdone < 0) kdone = k;
            end
            if (kdone >= 0 && k >= kdone + 3) break;
        end
        total++;
        if (nbytes != 2411) begin
            bad++;
            $display("FAIL panel_total: got %0d bytes required 2411", nbytes);
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL panel_done: got %0d done pulses required 1", ndone);
        end
        total++;
        if (b4 !== 9'h127 || b9 !== 9'h11D) begin
            bad++;
            $display("FAIL panel_ends: x1lo=%h y1lo=%h required 127 11d", b4, b9);
        end
    endtask

    task automatic test_reset_abort();
        x0 = 9'd0; x1 = 9'd15; y0 = 9'd0; y1 = 9'd0; color = 16'hABCD;
        run_fill(0, 1, 100, 31, 0);
        total++;
        if (timed_out || busy !== 1'b1 || done_cnt != 0) begin
            bad++;
            $display("FAIL abort_mid_fill: timeout=%b busy=%b done=%0d required 0/1/0", timed_out, busy, done_cnt);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (sif.spi_start !== 1'b0 || busy !== 1'b0 || sif.spi_data !== 8'h00) begin
            bad++;
            $display("FAIL abort_async: start=%b busy=%b data=%h required 0/0/00", sif.spi_start, busy, sif.spi_data);
        end
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_hold: done=%b busy=%b required 0/0", done, busy);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_wait: busy=%b done=%b required 0/0", busy, done);
        end
        set_small_window();
        run_fill(0, 1, 100, 0, 0);
        total++;
        if (bytes_q.size() != 15 || done_cnt != 1) begin
            bad++;
            $display("FAIL abort_restart_len: bytes=%0d done=%0d required 15/1", bytes_q.size(), done_cnt);
        end
        for (int i = 0; i < 15 && i < bytes_q.size(); i++) begin
            total++;
            if (bytes_q[i] !== exp_small[i]) begin
                bad++;
                $display("FAIL abort_restart_byte%0d: got %h required %h", i, bytes_q[i], exp_small[i]);
            end
        end
    endtask

    task automatic test_req_during_pixel();
        set_small_window();
        run_fill(0, 1, 100, 0, 12);
        total++;
        if (bytes_q.size() != 15 || done_cnt != 1) begin
            bad++;
            $display("FAIL busy_req_len: bytes=%0d done=%0d required 15/1", bytes_q.size(), done_cnt);
        end
        for (int i = 0; i < 15 && i < bytes_q.size(); i++) begin
            total++;
            if (bytes_q[i] !== exp_small[i]) begin
                bad++;
                $display("FAIL busy_req_byte%0d: got %h required %h", i, bytes_q[i], exp_small[i]);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || sif.spi_start !== 1'b0) begin
            bad++;
            $display("FAIL busy_req_no_refill: busy=%b start=%b required 0/0", busy, sif.spi_start);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; req = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        sif.spi_done = 1'b0;
        en_s = 1'b0; req_s = 1'b0;
        x0_s = '0; x1_s = '0; y0_s = '0; y1_s = '0; color_s = '0;
        sif_s.spi_done = 1'b0;

        test_reset();
        test_small_window();
        test_en_toggle();
        test_reject();
        test_full_screen_header();
        test_full_screen_small_panel();
        test_reset_abort();
        test_req_during_pixel();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_fill_sequencer.md
LCD_FILL_SEQUENCER -- requirements
Module: lcd_fill_sequencer

Interface
REQ-001 SHALL have parameter H_RES, default 320: panel width in pixels.
REQ-002 SHALL have parameter V_RES, default 240: panel height in pixels.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  SPI byte-clock enable strobe; state advances only on clk edges where en=1.
REQ-006 SHALL have port req  input  1  fill request, level-sampled.
REQ-007 SHALL have ports x0, x1, y0, y1  input  9 each  inclusive window corners.
REQ-008 SHALL have port color  input  16  RGB565 fill colour.
REQ-009 SHALL have port spi_start  output  1  byte pending for the SPI byte engine.
REQ-010 SHALL have port spi_data  output  8  byte to send.
REQ-011 SHALL have port spi_dc  output  1  0 = command byte, 1 = data byte.
REQ-012 SHALL have port spi_done  input  1  byte-complete pulse from the SPI byte engine.
REQ-013 SHALL have port busy  output  1  fill in progress.
REQ-014 SHALL have port done  output  1  one-clk pulse at fill completion.
REQ-015 SHALL have port err  output  1  one-clk pulse on a rejected request.

Function
REQ-016 SHALL, in IDLE on an en=1 cycle with req=1, latch x0/x1/y0/y1/color and leave IDLE; req SHALL be ignored while busy=1.
REQ-017 SHALL reject the request if x0>x1, y0>y1, x1>=H_RES or y1>=V_RES: err=1 for one clk, no byte issued, remain in IDLE.
REQ-018 SHALL sequence states IDLE -> CASET_CMD -> CASET_PAR -> PASET_CMD -> PASET_PAR -> RAMWR_CMD -> PIXEL -> IDLE.
REQ-019 SHALL emit, in order: 0x2A (dc=0); x0[15:8], x0[7:0], x1[15:8], x1[7:0] (dc=1, zero-extended to 16 bits); 0x2B (dc=0); the same four bytes for y0/y1; 0x2C (dc=0); then color[15:8], color[7:0] (dc=1), repeated (x1-x0+1)*(y1-y0+1) times.
REQ-020 SHALL hold spi_start=1 with spi_data/spi_dc stable while a byte is pending; a byte is consumed only on a clk edge with en=1 and spi_done=1, and the next byte SHALL appear on the following clk.
REQ-021 SHALL ignore spi_done when spi_start=0 and when en=0.
REQ-022 SHALL count pixels with a column counter (0..x1-x0) and a row counter (0..y1-y0), a hi/lo byte-phase bit and a 4-entry parameter-byte index; no multiplier.
REQ-023 SHALL, on consumption of the final pixel low byte, pulse done=1 for one clk, drop spi_start and busy in the same clk, and return to IDLE.
REQ-024 SHALL accept a new req no earlier than the next en=1 cycle after done.
REQ-025 SHALL drive busy=1 in every state except IDLE.
REQ-026 SHALL freeze all state, counters and outputs (except done/err, which are one-clk pulses) while en=0.
REQ-027 SHALL handle a single-pixel window (x0=x1, y0=y1) as exactly 13 bytes.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, all counters=0, spi_start=0, spi_data=0x00, spi_dc=0, busy=0, done=0, err=0, independent of clk.
REQ-029 SHALL abort any fill in progress when rst asserts, with no done pulse; after release, the block SHALL wait for a fresh req.

Structure
REQ-030 SHALL place opcodes (0x2A, 0x2B, 0x2C), the state enumeration and default H_RES/V_RES in shared package lcd_pkg.
REQ-031 SHALL implement the column/row/byte-phase counting in one sub-module, lcd_window_counter, with a last-pixel flag output.

Verification
REQ-032 SHALL cover: window x 0..1, y 0..0, color 0xF800, en=1 and spi_done every 4th clk -> bytes 2A,00,00,00,01,2B,00,00,00,00,2C,F8,00,F8,00 with dc 0,1,1,1,1,0,1,1,1,1,0,1,1,1,1, then one done pulse.
REQ-033 SHALL cover: full screen 0..319 x 0..239 -> x1 bytes 01,3F; y1 bytes 00,EF; 153611 bytes total; exactly one done.
REQ-034 SHALL cover: x0=5, x1=4 -> one err pulse, spi_start stays 0, busy stays 0.
REQ-035 SHALL cover: rst asserted after the 20th pixel byte -> spi_start=0 and busy=0 immediately, no done; next req restarts with 0x2A.
REQ-036 SHALL cover: en toggling 1/0 every clk, spi_done held 1 -> same byte sequence as REQ-032, one byte per en=1 cycle.
REQ-037 SHALL cover: req pulsed during PIXEL state -> ignored; only one fill completes.
